wand_line_rx: RTL

Receiver and presence responder for a single-wire, open-drain, wired-AND serial line. Idle line is pulled high. Remote initiators encode bits by low-pulse width. The block samples the resolved line, decodes the pulses into bytes, and hands each byte out on a valid/ready port. After a bus-reset pulse it answers with a presence pulse by pulling the line low. At the top level, `line_pull_o` drives the shared wand/tri1 net: low when asserted, `1'bz` otherwise.

---
 rtl/wand_rx_pkg.sv | 45 ++++
 rtl/line_sync.sv | 26 ++
 rtl/wand_line_rx.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/wand_rx_pkg.sv
// Shared types and default timing for the wired-AND line receiver.
package wand_rx_pkg;

    // Receiver control states.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOW      = 2'd1,
        PRESENCE = 2'd2,
        RELEASE  = 2'd3
    } rx_state_t;

    // What a completed low pulse means, by its width.
    typedef enum logic [1:0] {
        BIT1   = 2'd0,
        BIT0   = 2'd1,
        BAD    = 2'd2,
        BRESET = 2'd3
    } width_class_t;

    // Default timing, all in clock cycles.
    localparam int DEF_SYNC_STAGES  = 2;
    localparam int DEF_SHORT_MAX    = 15;
    localparam int DEF_BIT_MAX      = 60;
    localparam int DEF_RESET_MIN    = 240;
    localparam int DEF_PRESENCE_CYC = 120;
    localparam int DEF_CNT_W        = 9;

    // Map a low width onto its meaning. A width of 0 never reaches here.
    function automatic width_class_t classify_width(
        input int unsigned w,
        input int unsigned short_max,
        input int unsigned bit_max,
        input int unsigned reset_min
    );
        if (w <= short_max) begin
            return BIT1;
        end else if (w <= bit_max) begin
            return BIT0;
        end else if (w < reset_min) begin
            return BAD;
        end
        return BRESET;
    endfunction

endpackage

// File: rtl/line_sync.sv
// Flop chain bringing the asynchronous line into the clock domain.
// Resets to 1 so an idle (pulled-up) line is not mistaken for a low pulse.
// SYNC_STAGES must be at least 2.
module line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] r_sync;

    // Shift the raw line value through the chain; the last stage is the safe copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/wand_line_rx.sv
// Pulse-width receiver and presence responder for an open-drain wired-AND line.
// Low pulses are measured on the synchronized line, classified when the line
// returns high, shifted in LSB first and handed out on a valid/ready port.
module wand_line_rx
    import wand_rx_pkg::*;
#(
    parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter int SHORT_MAX    = DEF_SHORT_MAX,
    parameter int BIT_MAX      = DEF_BIT_MAX,
    parameter int RESET_MIN    = DEF_RESET_MIN,
    parameter int PRESENCE_CYC = DEF_PRESENCE_CYC,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       line_i,
    output logic       line_pull_o,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       bus_reset_o,
    output logic       err_o,
    output logic       ovf_o
);

    rx_state_t        r_state;
    logic [CNT_W-1:0] r_w;          // low width while in LOW, presence timer in PRESENCE
    logic [7:0]       r_shift;
    logic [2:0]       r_bitcnt;
    logic             r_pull;
    logic             r_err;
    logic             r_brst;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_ovf;

    logic             w_ls;
    width_class_t     w_class;
    logic             w_decode;
    logic             w_bit_ok;
    logic [7:0]       w_shift_new;
    logic             w_complete;
    logic             w_take;

    line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (line_i),
        .q_o  (w_ls)
    );

    // The classification happens in the first cycle the line is seen high again.
    assign w_class     = classify_width(32'(r_w), SHORT_MAX, BIT_MAX, RESET_MIN);
    assign w_decode    = (r_state == LOW) && w_ls;
    assign w_bit_ok    = w_decode && ((w_class == BIT1) || (w_class == BIT0));
    assign w_shift_new = {(w_class == BIT1), r_shift[7:1]};
    assign w_complete  = w_bit_ok && (r_bitcnt == 3'd7);
    assign w_take      = r_valid && ready_i;

    // Line FSM: width measurement, bit assembly, error/bus-reset pulses and presence pull.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_w      <= '0;
            r_shift  <= 8'h00;
            r_bitcnt <= 3'd0;
            r_pull   <= 1'b0;
            r_err    <= 1'b0;
            r_brst   <= 1'b0;
        end else begin
            r_err  <= 1'b0;
            r_brst <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_pull <= 1'b0;
                    if (!w_ls) begin
                        r_state <= LOW;
                        r_w     <= CNT_W'(1);
                    end
                end
                LOW: begin
                    if (!w_ls) begin
                        // Saturate so a very long low still reads as bus reset.
                        if (r_w != CNT_W'(RESET_MIN)) begin
                            r_w <= r_w + 1'b1;
                        end
                    end else begin
                        r_w <= '0;
                        case (w_class)
                            BIT1, BIT0: begin
                                r_state <= IDLE;
                                if (r_bitcnt == 3'd7) begin
                                    r_bitcnt <= 3'd0;
                                    r_shift  <= 8'h00;
                                end else begin
                                    r_bitcnt <= r_bitcnt + 3'd1;
                                    r_shift  <= w_shift_new;
                                end
                            end
                            BAD: begin
                                r_state  <= IDLE;
                                r_err    <= 1'b1;
                                r_shift  <= 8'h00;
                                r_bitcnt <= 3'd0;
                            end
                            default: begin
                                r_state  <= PRESENCE;
                                r_brst   <= 1'b1;
                                r_shift  <= 8'h00;
                                r_bitcnt <= 3'd0;
                            end
                        endcase
                    end
                end
                PRESENCE: begin
                    // Pull starts one cycle after the bus-reset pulse and lasts PRESENCE_CYC cycles.
                    if (r_w == CNT_W'(PRESENCE_CYC)) begin
                        r_pull  <= 1'b0;
                        r_w     <= '0;
                        r_state <= RELEASE;
                    end else begin
                        r_pull <= 1'b1;
                        r_w    <= r_w + 1'b1;
                    end
                end
                RELEASE: begin
                    // Our own pull is still draining through the synchronizer; wait it out.
                    r_pull <= 1'b0;
                    if (w_ls) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_pull  <= 1'b0;
                end
            endcase
        end
    end

    // Output holding register: load completed bytes, drop them when the slot is full and not draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_ovf <= 1'b0;
            if (w_complete) begin
                if (!r_valid || ready_i) begin
                    r_data  <= w_shift_new;
                    r_valid <= 1'b1;
                end else begin
                    r_ovf <= 1'b1;
                end
            end else if (w_take) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign line_pull_o = r_pull;
    assign data_o      = r_data;
    assign valid_o     = r_valid;
    assign bus_reset_o = r_brst;
    assign err_o       = r_err;
    assign ovf_o       = r_ovf;

endmodule
